// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the digit-serial BCD adder/subtractor.
// Contents: digit width, largest legal BCD digit, decimal radix, FSM state enum.
// Pure definitions; no logic.
package bcd_pkg;

    localparam int           DIGIT_W   = 4;
    localparam logic [3:0]   BCD_MAX   = 4'd9;
    localparam int           BCD_RADIX = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_slice.sv
// One BCD digit of add or ten's-complement subtract with decimal carry correction.
// Combinational, zero latency.
// No flow control; ports: x, y (digits), cin, sub in; digit, cout out.
module bcd_digit_slice
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               cin,
    input  logic               sub,
    output logic [DIGIT_W-1:0] digit,
    output logic               cout
);

    logic [DIGIT_W-1:0] w_y;
    logic [DIGIT_W:0]   w_sum;
    logic [DIGIT_W:0]   w_sum_adj;
    logic               w_gt;

    // Nine's complement of y in subtract mode; the +1 of ten's complement
    // enters as the initial carry of the least significant digit.
    assign w_y       = sub ? (BCD_MAX - y) : y;
    assign w_sum     = {1'b0, x} + {1'b0, w_y} + {{DIGIT_W{1'b0}}, cin};
    assign w_gt      = (w_sum > {1'b0, BCD_MAX});
    assign w_sum_adj = w_sum - (DIGIT_W+1)'(BCD_RADIX);

    assign digit = w_gt ? w_sum_adj[DIGIT_W-1:0] : w_sum[DIGIT_W-1:0];
    assign cout  = w_gt;

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: N_DIGITS digits through one correction slice.
// Latency: start edge k -> done pulse at edge k+N_DIGITS; next start at k+N_DIGITS+2.
// No queueing: start is only sampled in IDLE; result/cout/invalid held until next start.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter  int N_DIGITS = 4,
    localparam int CNT_W    = $clog2(N_DIGITS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        op_sub,
    input  logic [DIGIT_W*N_DIGITS-1:0] a,
    input  logic [DIGIT_W*N_DIGITS-1:0] b,
    output logic                        busy,
    output logic                        done,
    output logic [DIGIT_W*N_DIGITS-1:0] result,
    output logic                        cout,
    output logic                        invalid
);

    localparam int W = DIGIT_W * N_DIGITS;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_sub;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_result;
    logic               r_cout;
    logic               r_invalid;

    logic               w_last;
    logic               w_inv_scan;
    logic [DIGIT_W-1:0] w_x;
    logic [DIGIT_W-1:0] w_y;
    logic [DIGIT_W-1:0] w_digit;
    logic               w_c;
    logic [W-1:0]       w_res_upd;

    assign w_last = (r_cnt == CNT_W'(N_DIGITS - 1));

    // Any non-decimal nibble in either incoming operand.
    always_comb begin
        w_inv_scan = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if ((a[i*DIGIT_W +: DIGIT_W] > BCD_MAX) || (b[i*DIGIT_W +: DIGIT_W] > BCD_MAX)) begin
                w_inv_scan = 1'b1;
            end
        end
    end

    // Select the operand digits addressed by the counter.
    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (CNT_W'(i) == r_cnt) begin
                w_x = r_a[i*DIGIT_W +: DIGIT_W];
                w_y = r_b[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    bcd_digit_slice u_slice (
        .x     (w_x),
        .y     (w_y),
        .cin   (r_carry),
        .sub   (r_sub),
        .digit (w_digit),
        .cout  (w_c)
    );

    // Current result with the digit at the counter position replaced.
    always_comb begin
        w_res_upd = r_result;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (CNT_W'(i) == r_cnt) begin
                w_res_upd[i*DIGIT_W +: DIGIT_W] = w_digit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sub     <= 1'b0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_cout    <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_sub     <= op_sub;
                        r_carry   <= op_sub;
                        r_cnt     <= '0;
                        r_invalid <= w_inv_scan;
                    end
                end
                RUN: begin
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // Invalid operands publish a zero result and no carry.
                        r_result <= r_invalid ? '0   : w_res_upd;
                        r_cout   <= r_invalid ? 1'b0 : w_c;
                    end else begin
                        r_result <= w_res_upd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state == RUN);
    assign done    = (r_state == DONE);
    assign result  = r_result;
    assign cout    = r_cout;
    assign invalid = r_invalid;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
module tb_bcd_serial_addsub;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, invalid;
    logic [W-1:0] result;

    logic         start1 = 1'b0;
    logic         sub1 = 1'b0;
    logic [3:0]   a1 = '0;
    logic [3:0]   b1 = '0;
    logic         busy1, done1, cout1, inv1;
    logic [3:0]   res1;

    always #5 clk = ~clk;

    bcd_serial_addsub #(.N_DIGITS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
        .a(a), .b(b), .busy(busy), .done(done),
        .result(result), .cout(cout), .invalid(invalid)
    );

    bcd_serial_addsub #(.N_DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_sub(sub1),
        .a(a1), .b(b1), .busy(busy1), .done(done1),
        .result(res1), .cout(cout1), .invalid(inv1)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: decimal arithmetic on the operand values.
    // Returns {invalid, cout, result[15:0]} with result BCD-packed.
    function automatic logic [17:0] ref_op(input int n, input logic [15:0] ra,
                                           input logic [15:0] rb, input logic rs);
        longint va = 0, vb = 0, md = 1, r;
        bit inv = 0;
        bit c;
        logic [15:0] res = '0;
        for (int i = 0; i < n; i++) begin
            int da = int'(ra[4*i +: 4]);
            int db = int'(rb[4*i +: 4]);
            if (da > 9 || db > 9) inv = 1;
            va += da * md;
            vb += db * md;
            md *= 10;
        end
        if (inv) return {1'b1, 1'b0, 16'h0};
        if (!rs) begin
            r = va + vb;
            c = (r >= md);
        end else begin
            r = va - vb + md;
            c = (va >= vb);
        end
        r = r % md;
        for (int i = 0; i < n; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return {inv, c, res};
    endfunction

    // Transaction-level timing model: a start is accepted if none is in
    // flight or at least N+2 edges have passed since the last accepted one.
    int          cyc = 0;
    int          m_k = 0;
    bit          m_act = 0;
    bit          m_have = 1;
    logic [17:0] m_exp = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_act = 0; m_have = 1; m_exp = '0;
        end else begin
            cyc++;
            if (start && (!m_act || cyc >= m_k + N + 2)) begin
                m_act  = 1;
                m_k    = cyc;
                m_have = 0;
                m_exp  = ref_op(N, a, b, op_sub);
            end
            if (m_act && cyc == m_k + N) m_have = 1;
        end
    end

    always @(negedge clk) begin : cmp
        bit eb, ed;
        if (rst_n) begin
            eb = m_act && (cyc >= m_k) && (cyc < m_k + N);
            ed = m_act && (cyc == m_k + N);
            chk("busy", busy, eb);
            chk("done", done, ed);
            if (m_have) begin
                chk("result", result, m_exp[15:0]);
                chk("cout", cout, m_exp[16]);
                chk("invalid", invalid, m_exp[17]);
            end
        end
    end

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                         input bit hold, input logic [17:0] lit, input string nm);
        int lat;
        chk({nm, " model"}, 32'(ref_op(N, ta, tb_, ts)), 32'(lit));
        @(negedge clk);
        a = ta; b = tb_; op_sub = ts; start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        a = rand_bcd(); b = rand_bcd(); op_sub = ~ts;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, N);
        chk({nm, " result"}, result, lit[15:0]);
        chk({nm, " cout"}, cout, lit[16]);
        chk({nm, " invalid"}, invalid, lit[17]);
        if (hold) begin
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk({nm, " no second op"}, busy, 1'b0);
        end
    endtask

    task automatic do_op1(input logic [3:0] ta, input logic [3:0] tb_, input logic ts,
                          input logic [17:0] lit, input string nm);
        int lat;
        chk({nm, " model"}, 32'(ref_op(1, {12'h0, ta}, {12'h0, tb_}, ts)), 32'(lit));
        @(negedge clk);
        a1 = ta; b1 = tb_; sub1 = ts; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk({nm, " busy"}, busy1, 1'b1);
        lat = 0;
        while (!done1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, 1);
        chk({nm, " result"}, res1, lit[3:0]);
        chk({nm, " cout"}, cout1, lit[16]);
        chk({nm, " invalid"}, inv1, lit[17]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dcount;
        #12;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 16'h0);
        chk("reset cout", cout, 1'b0);
        chk("reset invalid", invalid, 1'b0);
        #11 rst_n = 1'b1;

        do_op(16'h1234, 16'h5678, 1'b0, 0, {1'b0, 1'b0, 16'h6912}, "add");
        do_op(16'h9999, 16'h0001, 1'b0, 0, {1'b0, 1'b1, 16'h0000}, "add ovf");
        do_op(16'h9999, 16'h0001, 1'b0, 1, {1'b0, 1'b1, 16'h0000}, "add ovf hold");
        do_op(16'h12A4, 16'h0001, 1'b0, 0, {1'b1, 1'b0, 16'h0000}, "invalid");
        do_op(16'h1234, 16'h5000, 1'b1, 0, {1'b0, 1'b0, 16'h6234}, "sub neg");
        do_op(16'h5000, 16'h1234, 1'b1, 0, {1'b0, 1'b1, 16'h3766}, "sub pos");

        // Abort during the second RUN cycle.
        @(negedge clk);
        a = 16'h9999; b = 16'h0001; op_sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort result", result, 16'h0);
        chk("abort cout", cout, 1'b0);
        chk("abort invalid", invalid, 1'b0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort no done", dcount, 0);
        do_op(16'h0005, 16'h0005, 1'b0, 0, {1'b0, 1'b0, 16'h0010}, "after abort");

        do_op1(4'd7, 4'd8, 1'b0, {1'b0, 1'b1, 16'h0005}, "n1 add");
        do_op1(4'd3, 4'd8, 1'b1, {1'b0, 1'b0, 16'h0005}, "n1 sub");

        // Random traffic: start pulses land in every state and operands
        // change every cycle, so latching and start-ignore are exercised.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 3) == 0);
            op_sub = 1'($urandom);
            a      = rand_bcd();
            b      = rand_bcd();
        end
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Parametrised, digit-serial BCD adder/subtractor; the next generation of the team's single-digit BCD adder.
- Handles N_DIGITS packed BCD digits, one digit per clock, through one correction slice.
- Adds a subtract mode (ten's complement), a start/busy/done handshake, held results and an invalid-digit flag.
- Sits between the operand registers and the display/accumulator path.

Parameters:
- N_DIGITS, 4, number of BCD digits per operand; legal range ≥1.
- CNT_W, $clog2(N_DIGITS+1), digit-counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- op_sub  in  1  0 = A+B, 1 = A−B; latched with start.
- a  in  4*N_DIGITS  operand A; digit i at a[4i+3:4i], i=0 least significant.
- b  in  4*N_DIGITS  operand B, same packing.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when result, cout and invalid are valid.
- result  out  4*N_DIGITS  BCD result; held until the next accepted start.
- cout  out  1  add mode: decimal carry out. Sub mode: 1 = no borrow (A≥B).
- invalid  out  1  1 if any latched digit of A or B is >9.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, result=0, cout=0, invalid=0; counter=0; internal carry=0.
- Reset mid-operation aborts immediately and produces no done. After release the block is in IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge k latches a, b and op_sub. Sets carry=op_sub, counter=0, invalid=OR of (digit>9) over all 2·N_DIGITS digits. Goes to RUN; busy=1 from edge k.
  - RUN: each edge processes digit index=counter and writes result digit[counter]; counter increments. After digit N_DIGITS−1 (edge k+N_DIGITS) goes to DONE, busy=0, done=1.
  - DONE: lasts one cycle. Next edge goes to IDLE unconditionally with done=0.
  - start is ignored in RUN and DONE; there is no queueing. op_sub, a and b changes after the start edge have no effect.
- Latency: start edge k to done high at edge k+N_DIGITS. A new start is accepted no earlier than edge k+N_DIGITS+2.
- Digit step (per-digit slice):
  - y' = op_sub ? 9−y : y.
  - s = x + y' + c, 5-bit, maximum 19.
  - If s>9: digit = s−10, c_next=1. Otherwise digit = s, c_next=0.
- cout takes the final carry at edge k+N_DIGITS.
- Subtraction is modulo 10^N_DIGITS. A<B yields the ten's-complement result with cout=0.
- Invalid:
  - If invalid=1, result is forced to all zeros and cout=0 at the done edge.
  - busy/done timing is unchanged.
  - invalid is held with result.
- result, cout and invalid hold their values from done until the next accepted start. Intermediate digits are visible in result during RUN and are not guaranteed meaningful until done.
- N_DIGITS=1 behaves as a single-digit adder with 1-cycle RUN.

Decomposition:
- Package bcd_pkg: DIGIT_W=4, BCD_MAX=4'd9, BCD_RADIX=10, state enum {IDLE, RUN, DONE}.
- Sub-module bcd_digit_slice: combinational; inputs x, y, cin, sub; outputs digit, cout.
- The top holds the FSM, counter, operand/result registers and the invalid scan.

Test Plan (N_DIGITS=4 unless stated):
- Add: a=1234, b=5678, op_sub=0, start → done exactly 4 cycles after start edge; result=6912, cout=0, invalid=0; busy high for 4 cycles.
- Add overflow: a=9999, b=0001 → result=0000, cout=1. Same again with start held high through RUN and DONE → only one operation is accepted.
- Subtract: a=5000, b=1234, op_sub=1 → result=3766, cout=1. Then a=1234, b=5000 → result=6234, cout=0.
- Invalid: a=12A4 (hex nibble A), b=0001 → invalid=1, result=0000, cout=0; done still 4 cycles after start.
- Reset mid-op: start 9999+0001, drop rst_n at RUN cycle 2 → all outputs 0 immediately, no done. After release a new 0005+0005 gives 0010.
- N_DIGITS=1 build: a=7, b=8 → result=5, cout=1, done 1 cycle after start; a=3, b=8, op_sub=1 → result=5, cout=0.
